// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch front-end sequencer: redirect arbitration, stalls, halt/resume, perf counters
module fetch_sequencer #(
    parameter int BOOT_CYC = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_taken,
    input  logic [29:0]      br_target,
    input  logic             jmp_valid,
    input  logic [29:0]      jmp_target,
    input  logic             load_use,
    input  logic             halt_req,
    input  logic             resume,
    output logic             PC_Src,
    output logic [29:0]      Target_PC_Addr,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;
    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYC - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] boot_cnt_q, boot_cnt_d;
    logic       stall_inc, redir_inc;

    assign state = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = 4'd0;
        case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q >= BOOT_LAST) state_d = ST_RUN;
                else                         boot_cnt_d = boot_cnt_q + 4'd1;
            end
            ST_RUN: begin
                // halt only wins when no higher-priority request is present
                if (!br_taken && !load_use && !jmp_valid && halt_req) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (resume) state_d = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        PC_Src         = 1'b0;
        Target_PC_Addr = 30'd0;
        pc_stall       = 1'b0;
        ifid_stall     = 1'b0;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        stall_inc      = 1'b0;
        redir_inc      = 1'b0;
        if (!rst) begin
            pc_stall   = 1'b1;
            ifid_flush = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (br_taken) begin
                        PC_Src         = 1'b1;
                        Target_PC_Addr = br_target;
                        ifid_flush     = 1'b1;
                        idex_flush     = 1'b1;
                        redir_inc      = 1'b1;
                    end else if (load_use) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end else if (jmp_valid) begin
                        PC_Src         = 1'b1;
                        Target_PC_Addr = jmp_target;
                        ifid_flush     = 1'b1;
                        redir_inc      = 1'b1;
                    end else if (halt_req) begin
                        pc_stall   = 1'b1;
                        ifid_flush = 1'b1;
                    end
                end
                default: begin
                    pc_stall   = 1'b1;
                    ifid_flush = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))    stall_cnt    <= stall_cnt + 1'b1;
            if (redir_inc && (redirect_cnt != {CNT_W{1'b1}})) redirect_cnt <= redirect_cnt + 1'b1;
        end
    end

endmodule
